// File: rtl/wb_grf.sv
// Write-back stage and general register file of the five-stage MIPS pipeline.
// Selects/extends the write-back value, writes the 32x32 register file ($0 fixed
// at zero), serves two combinational decode read ports with same-cycle bypass,
// and counts retired (valid) instructions.
module wb_grf #(
  parameter int REG_COUNT = 32,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite_W,
  input  logic [3:0]       MemtoReg_W,
  input  logic [31:0]      PC_W,
  input  logic [31:0]      PC8_W,
  input  logic [31:0]      ALUresult_W,
  input  logic [31:0]      MemOutput_W,
  input  logic [4:0]       Dst_W,
  input  logic             newsign_W,
  input  logic [4:0]       A1_D,
  input  logic [4:0]       A2_D,
  output logic [31:0]      RD1_D,
  output logic [31:0]      RD2_D,
  output logic [31:0]      WD_W,
  output logic [4:0]       FwdDst_W,
  output logic [CNT_W-1:0] Retired
);

  logic [31:0] regs [0:REG_COUNT-1];
  logic        eff_wr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        pc_unused;

  // PC_W travels with the instruction but plays no part in write-back.
  assign pc_unused = ^PC_W;

  // Extend a loaded byte; sgn selects lb (sign) versus lbu (zero).
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] sx;
    sb = b;
    sx = sb;
    return sgn ? sx : {24'd0, b};
  endfunction

  // Extend a loaded halfword; sgn selects lh (sign) versus lhu (zero).
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    sh = h;
    sx = sh;
    return sgn ? sx : {16'd0, h};
  endfunction

  // A write only lands when the instruction is real, enabled, and not aimed at $0.
  assign eff_wr   = RegWrite_W & newsign_W & (Dst_W != 5'd0);
  assign FwdDst_W = eff_wr ? Dst_W : 5'd0;

  // Lane extraction and write-back source selection.
  always_comb begin
    byte_sel = MemOutput_W[7:0];
    case (ALUresult_W[1:0])
      2'd0: byte_sel = MemOutput_W[7:0];
      2'd1: byte_sel = MemOutput_W[15:8];
      2'd2: byte_sel = MemOutput_W[23:16];
      2'd3: byte_sel = MemOutput_W[31:24];
    endcase
    // Halfword lane ignores ALUresult_W[0]; misaligned lh/lhu are not trapped here.
    half_sel = ALUresult_W[1] ? MemOutput_W[31:16] : MemOutput_W[15:0];
    WD_W = ALUresult_W;
    case (MemtoReg_W)
      4'd1:    WD_W = MemOutput_W;
      4'd2:    WD_W = PC8_W;
      4'd3:    WD_W = ext_byte(byte_sel, 1'b1);
      4'd4:    WD_W = ext_byte(byte_sel, 1'b0);
      4'd5:    WD_W = ext_half(half_sel, 1'b1);
      4'd6:    WD_W = ext_half(half_sel, 1'b0);
      default: WD_W = ALUresult_W;
    endcase
  end

  // Register storage: cleared asynchronously, written on effective writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (eff_wr) begin
      regs[Dst_W] <= WD_W;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Retired <= '0;
    end else if (newsign_W) begin
      Retired <= Retired + CNT_W'(1);
    end
  end

  // Read ports: zero during reset and for $0, otherwise bypass or storage.
  always_comb begin
    RD1_D = '0;
    RD2_D = '0;
    if (reset && A1_D != 5'd0)
      RD1_D = (eff_wr && A1_D == Dst_W) ? WD_W : regs[A1_D];
    if (reset && A2_D != 5'd0)
      RD2_D = (eff_wr && A2_D == Dst_W) ? WD_W : regs[A2_D];
  end

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: vector table for write-back selection, bypass and
// storage, plus hand sequences for reset, bubbles and counter wrap.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rw = 1'b0;
  logic [3:0]  mtr = 4'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] pc8 = 32'd0;
  logic [31:0] alu = 32'd0;
  logic [31:0] mem = 32'd0;
  logic [4:0]  dst = 5'd0;
  logic        vld = 1'b0;
  logic [4:0]  a1 = 5'd0;
  logic [4:0]  a2 = 5'd0;
  logic [31:0] rd1, rd2, wd;
  logic [4:0]  fwd;
  logic [31:0] retired;
  logic [31:0] rd1_n, rd2_n, wd_n;
  logic [4:0]  fwd_n;
  logic [3:0]  retired4;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [0:31];
  logic [31:0] ret_mdl = 32'd0;

  typedef struct {
    logic        rw;
    logic        vld;
    logic [3:0]  mtr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc8;
    logic [4:0]  dst;
    logic [31:0] exp_wd;
    logic [4:0]  exp_fwd;
  } vec_t;

  vec_t vecs [0:15];

  wb_grf dut (
    .clk(clk), .reset(reset), .RegWrite_W(rw), .MemtoReg_W(mtr), .PC_W(pc),
    .PC8_W(pc8), .ALUresult_W(alu), .MemOutput_W(mem), .Dst_W(dst),
    .newsign_W(vld), .A1_D(a1), .A2_D(a2), .RD1_D(rd1), .RD2_D(rd2),
    .WD_W(wd), .FwdDst_W(fwd), .Retired(retired)
  );

  wb_grf #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .RegWrite_W(rw), .MemtoReg_W(mtr), .PC_W(pc),
    .PC8_W(pc8), .ALUresult_W(alu), .MemOutput_W(mem), .Dst_W(dst),
    .newsign_W(vld), .A1_D(a1), .A2_D(a2), .RD1_D(rd1_n), .RD2_D(rd2_n),
    .WD_W(wd_n), .FwdDst_W(fwd_n), .Retired(retired4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] me,
                       input logic [31:0] p8, input logic [4:0] d);
    rw = r; vld = v; mtr = m; alu = a; mem = me; pc8 = p8; dst = d;
    pc = p8 - 32'd8;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    ret_mdl = 32'd0;
  endtask

  // Present one ALU-result instruction for a cycle and update the model.
  task automatic step(input logic r, input logic v, input logic [31:0] data, input logic [4:0] d);
    @(negedge clk);
    drive(r, v, 4'd0, data, 32'd0, 32'd0, d);
    @(posedge clk);
    #1;
    if (r && v && d != 5'd0) mdl[d] = data;
    if (v) ret_mdl = ret_mdl + 32'd1;
    idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    clear_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'd0,  32'hDEADBEEF, 32'h0,        32'h0,    5'd8,  32'hDEADBEEF, 5'd8};
    vecs[1]  = '{1'b1, 1'b1, 4'd0,  32'hFFFFFFFF, 32'h0,        32'h0,    5'd0,  32'hFFFFFFFF, 5'd0};
    vecs[2]  = '{1'b1, 1'b1, 4'd3,  32'h00000103, 32'h80FF7F01, 32'h0,    5'd9,  32'hFFFFFF80, 5'd9};
    vecs[3]  = '{1'b1, 1'b1, 4'd4,  32'h00000001, 32'h80FF7F01, 32'h0,    5'd10, 32'h0000007F, 5'd10};
    vecs[4]  = '{1'b1, 1'b1, 4'd5,  32'h00000002, 32'h80FF7F01, 32'h0,    5'd11, 32'hFFFF80FF, 5'd11};
    vecs[5]  = '{1'b1, 1'b1, 4'd6,  32'h00000000, 32'h80FF7F01, 32'h0,    5'd12, 32'h00007F01, 5'd12};
    vecs[6]  = '{1'b1, 1'b1, 4'd2,  32'h00000000, 32'h80FF7F01, 32'h3008, 5'd31, 32'h00003008, 5'd31};
    vecs[7]  = '{1'b1, 1'b1, 4'd1,  32'h00000002, 32'h80FF7F01, 32'h0,    5'd13, 32'h80FF7F01, 5'd13};
    vecs[8]  = '{1'b1, 1'b1, 4'd9,  32'h12345678, 32'h80FF7F01, 32'h3008, 5'd14, 32'h12345678, 5'd14};
    vecs[9]  = '{1'b1, 1'b1, 4'd5,  32'h00000003, 32'h80FF7F01, 32'h0,    5'd15, 32'hFFFF80FF, 5'd15};
    vecs[10] = '{1'b1, 1'b1, 4'd3,  32'h00000000, 32'h80FF7F01, 32'h0,    5'd16, 32'h00000001, 5'd16};
    vecs[11] = '{1'b1, 1'b1, 4'd4,  32'h00000002, 32'h80FF7F01, 32'h0,    5'd17, 32'h000000FF, 5'd17};
    vecs[12] = '{1'b0, 1'b1, 4'd0,  32'h00000000, 32'h0,        32'h0,    5'd8,  32'h00000000, 5'd0};
    vecs[13] = '{1'b1, 1'b0, 4'd0,  32'h00000055, 32'h0,        32'h0,    5'd8,  32'h00000055, 5'd0};
    vecs[14] = '{1'b1, 1'b1, 4'd15, 32'hCAFEF00D, 32'h80FF7F01, 32'h3008, 5'd18, 32'hCAFEF00D, 5'd18};
    vecs[15] = '{1'b1, 1'b1, 4'd6,  32'h00000003, 32'h80FF7F01, 32'h0,    5'd8,  32'h000080FF, 5'd8};

    clear_model();

    // Initial asynchronous reset, before any clock edge.
    a1 = 5'd5; a2 = 5'd5;
    #2 reset = 1'b0;
    #1;
    check("init_rd1", rd1, 32'd0);
    check("init_retired", retired, 32'd0);
    check("init_retired4", {28'd0, retired4}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Write $5 = 0x1234, then reset asynchronously mid-cycle.
    step(1'b1, 1'b1, 32'h1234, 5'd5);
    a1 = 5'd5; a2 = 5'd5;
    #1;
    check("r5_stored", rd1, 32'h1234);
    check("retired_one", retired, ret_mdl);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_rd1", rd1, 32'd0);
    check("async_rst_rd2", rd2, 32'd0);
    check("async_rst_retired", retired, 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("r5_cleared", rd1, 32'd0);

    // Reset wins over a write in the same cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd0, 32'h77, 32'd0, 32'd0, 5'd6);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle();
    reset = 1'b1;
    a1 = 5'd6;
    #1;
    check("rst_vs_write_r6", rd1, 32'd0);
    check("rst_vs_write_cnt", retired, 32'd0);

    // Table of write-back vectors: same-cycle bypass, then storage.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].rw, vecs[i].vld, vecs[i].mtr, vecs[i].alu, vecs[i].mem, vecs[i].pc8, vecs[i].dst);
      a1 = vecs[i].dst; a2 = vecs[i].dst;
      #1;
      check($sformatf("v%0d_wd", i), wd, vecs[i].exp_wd);
      check($sformatf("v%0d_fwd", i), {27'd0, fwd}, {27'd0, vecs[i].exp_fwd});
      check($sformatf("v%0d_byp1", i), rd1, (vecs[i].exp_fwd != 5'd0) ? vecs[i].exp_wd : mdl[vecs[i].dst]);
      check($sformatf("v%0d_byp2", i), rd2, (vecs[i].exp_fwd != 5'd0) ? vecs[i].exp_wd : mdl[vecs[i].dst]);
      @(posedge clk);
      #1;
      if (vecs[i].exp_fwd != 5'd0) mdl[vecs[i].exp_fwd] = vecs[i].exp_wd;
      if (vecs[i].vld) ret_mdl = ret_mdl + 32'd1;
      idle();
      #1;
      check($sformatf("v%0d_stored", i), rd1, mdl[vecs[i].dst]);
      check($sformatf("v%0d_retired", i), retired, ret_mdl);
    end

    // Earlier vectors still held after later writes.
    a1 = 5'd9; a2 = 5'd31;
    #1;
    check("hold_r9", rd1, 32'hFFFFFF80);
    check("hold_r31", rd2, 32'h00003008);

    // Bubbles: five valid instructions, then three bubbles targeting $21.
    pulse_reset();
    step(1'b1, 1'b1, 32'h21, 5'd21);
    step(1'b0, 1'b1, 32'h99, 5'd22);
    step(1'b1, 1'b1, 32'h23, 5'd23);
    step(1'b0, 1'b1, 32'h98, 5'd24);
    step(1'b1, 1'b1, 32'h25, 5'd25);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'hBAD, 5'd21);
    a1 = 5'd21; a2 = 5'd22;
    #1;
    check("bubble_retired", retired, 32'd5);
    check("bubble_r21", rd1, 32'h21);
    check("rw0_r22", rd2, 32'd0);
    a1 = 5'd25; a2 = 5'd23;
    #1;
    check("valid_r25", rd1, 32'h25);
    check("valid_r23", rd2, 32'h23);

    // Counter wrap on the 4-bit instance.
    pulse_reset();
    for (int k = 0; k < 17; k++) step(1'b0, 1'b1, 32'd0, 5'd0);
    #1;
    check("wrap_retired4", {28'd0, retired4}, 32'd1);
    check("wrap_retired32", retired, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
